// File: rtl/logic_gate_pkg.sv
// Shared definitions for the registered logic-gate family (and/or/xor).
// Holds the legal parameter limits and the elaboration-time range check
// that every gate wrapper uses before building its pipeline.
package logic_gate_pkg;

    localparam int MAX_PIPE_STAGES = 8;
    localparam int MAX_WIDTH       = 1024;

    // True when a gate's WIDTH / PIPE_STAGES pair is inside the supported range.
    function automatic bit gate_params_ok(input int width, input int stages);
        return (width >= 1) && (width <= MAX_WIDTH) &&
               (stages >= 0) && (stages <= MAX_PIPE_STAGES);
    endfunction

endpackage

// File: rtl/gate_pipe.sv
// Generic N-stage register chain that clears asynchronously on reset.
// N=0 degenerates to a wire so the owning gate becomes purely combinational.
module gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (N < 0 || N > MAX_PIPE_STAGES) begin : g_bad_n
        $fatal(1, "gate_pipe: N=%0d outside 0..%0d", N, MAX_PIPE_STAGES);
    end

    if (N == 0) begin : g_bypass
        // Clock and reset are intentionally unused on the combinational path.
        logic unused_bypass;
        assign unused_bypass = clk ^ rst_n;
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] stage_q [N];
        logic [W-1:0] stage_d [N];

        // Stage 0 takes the input; every later stage takes its predecessor.
        for (genvar gi = 0; gi < N; gi++) begin : g_link
            if (gi == 0) begin : g_head
                assign stage_d[gi] = d_i;
            end else begin : g_tail
                assign stage_d[gi] = stage_q[gi-1];
            end
        end

        // Shift the whole chain each cycle; reset flushes every in-flight word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign q_o = stage_q[N-1];
    end

endmodule

// File: rtl/and_gate_reg.sv
// Pipelined bitwise AND of two buses with valid qualifier and all-ones /
// any-one reduction flags travelling alongside the data.
// The valid bit rides in the same register chain as the data so the two can
// never drift apart; data is captured every cycle regardless of in_valid.
module and_gate_reg
    import logic_gate_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_all,
    output logic             out_any
);

    if (!gate_params_ok(WIDTH, PIPE_STAGES)) begin : g_bad_params
        $fatal(1, "and_gate_reg: WIDTH=%0d (1..%0d) PIPE_STAGES=%0d (0..%0d) illegal",
               WIDTH, MAX_WIDTH, PIPE_STAGES, MAX_PIPE_STAGES);
    end

    logic [WIDTH-1:0] res;
    logic             res_all;
    logic             res_any;
    logic [WIDTH+2:0] pipe_in;
    logic [WIDTH+2:0] pipe_out;

    // Reductions are computed before the pipeline so the output side has no
    // wide reduction tree after the last register.
    assign res     = in_a & in_b;
    assign res_all = &res;
    assign res_any = |res;
    assign pipe_in = {in_valid, res_any, res_all, res};

    gate_pipe #(
        .W (WIDTH + 3),
        .N (PIPE_STAGES)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pipe_in),
        .q_o   (pipe_out)
    );

    assign out       = pipe_out[WIDTH-1:0];
    assign out_all   = pipe_out[WIDTH];
    assign out_any   = pipe_out[WIDTH+1];
    assign out_valid = pipe_out[WIDTH+2];

`ifndef SYNTHESIS
    if (PIPE_STAGES > 0) begin : g_checks
        a_valid_low_in_reset: assert property (@(posedge clk) !rst_n |-> !out_valid);
        a_data_latency: assert property (@(posedge clk) disable iff (!rst_n)
            out_valid |-> (out == $past(in_a & in_b, PIPE_STAGES)));
    end
`endif

endmodule

// File: tb/tb_and_gate_reg.sv
// Bench for and_gate_reg: five instances cover the combinational gate, the
// single-stage gate and deeper pipelines; each pipelined scenario keeps its
// own queue of driven inputs and derives expected outputs from a & b.
module tb_and_gate_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // WIDTH=1, PIPE_STAGES=0
    logic v0 = 0, a0 = 0, b0 = 0, ov0, o0, all0, any0;
    // WIDTH=1, PIPE_STAGES=1
    logic v1 = 0, a1 = 0, b1 = 0, ov1, o1, all1, any1;
    // WIDTH=8, PIPE_STAGES=3
    logic v3 = 0, ov3, all3, any3;
    logic [7:0] a3 = 0, b3 = 0, o3;
    // WIDTH=8, PIPE_STAGES=2
    logic v2 = 0, ov2, all2, any2;
    logic [7:0] a2 = 0, b2 = 0, o2;
    // WIDTH=16, PIPE_STAGES=4
    logic v4 = 0, ov4, all4, any4;
    logic [15:0] a4 = 0, b4 = 0, o4;

    and_gate_reg #(.WIDTH(1), .PIPE_STAGES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_a(a0), .in_b(b0),
        .out_valid(ov0), .out(o0), .out_all(all0), .out_any(any0));
    and_gate_reg #(.WIDTH(1), .PIPE_STAGES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_a(a1), .in_b(b1),
        .out_valid(ov1), .out(o1), .out_all(all1), .out_any(any1));
    and_gate_reg #(.WIDTH(8), .PIPE_STAGES(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_a(a3), .in_b(b3),
        .out_valid(ov3), .out(o3), .out_all(all3), .out_any(any3));
    and_gate_reg #(.WIDTH(8), .PIPE_STAGES(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_a(a2), .in_b(b2),
        .out_valid(ov2), .out(o2), .out_all(all2), .out_any(any2));
    and_gate_reg #(.WIDTH(16), .PIPE_STAGES(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_a(a4), .in_b(b4),
        .out_valid(ov4), .out(o4), .out_all(all4), .out_any(any4));

    task automatic test_reset();
        a0 = 1; b0 = 1; v0 = 1;
        #3;
        tests++;
        if ({ov1, o1, all1, any1} !== 4'b0) begin
            fails++; $display("FAIL reset_d1 {v,o,all,any} got %b want 0000", {ov1, o1, all1, any1});
        end
        tests++;
        if ({ov2, o2, all2, any2} !== 11'b0) begin
            fails++; $display("FAIL reset_d2 {v,o,all,any} got %h want 000", {ov2, o2, all2, any2});
        end
        tests++;
        if ({ov3, o3, all3, any3} !== 11'b0) begin
            fails++; $display("FAIL reset_d3 {v,o,all,any} got %h want 000", {ov3, o3, all3, any3});
        end
        tests++;
        if ({ov4, o4, all4, any4} !== 19'b0) begin
            fails++; $display("FAIL reset_d4 {v,o,all,any} got %h want 00000", {ov4, o4, all4, any4});
        end
        tests++;
        if ({ov0, o0, all0, any0} !== 4'b1111) begin
            fails++; $display("FAIL reset_comb_d0 {v,o,all,any} got %b want 1111", {ov0, o0, all0, any0});
        end
        @(negedge clk);
        @(negedge clk);
        a0 = 0; b0 = 0; v0 = 0;
        rst_n = 1;
        $display("[TB] reset released at %0t", $time);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_w1_p0();
        logic er;
        for (int i = 0; i < 4; i++) begin
            a0 = i[0]; b0 = i[1]; v0 = 1;
            er = (a0 == 1'b1 && b0 == 1'b1);
            #1;
            $display("[TB] w1p0 a=%b b=%b out=%b all=%b any=%b v=%b", a0, b0, o0, all0, any0, ov0);
            tests++;
            if (o0 !== er) begin fails++; $display("FAIL w1p0_out[%0d] got %b want %b", i, o0, er); end
            tests++;
            if (all0 !== er || any0 !== er) begin
                fails++; $display("FAIL w1p0_flags[%0d] got all=%b any=%b want %b", i, all0, any0, er);
            end
            tests++;
            if (ov0 !== 1'b1) begin fails++; $display("FAIL w1p0_valid[%0d] got %b want 1", i, ov0); end
            #9;
        end
        v0 = 0; a0 = 0; b0 = 0;
        #1;
        tests++;
        if (ov0 !== 1'b0) begin fails++; $display("FAIL w1p0_valid_low got %b want 0", ov0); end
        @(negedge clk);
    endtask

    task automatic test_w1_p1();
        logic qa[$], qb[$], qv[$];
        logic ea, eb, ev, er;
        qa.push_back(0); qb.push_back(0); qv.push_back(0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ea = qa.pop_front(); eb = qb.pop_front(); ev = qv.pop_front();
            er = (ea == 1'b1 && eb == 1'b1);
            $display("[TB] w1p1 cyc%0d out=%b all=%b any=%b v=%b", i, o1, all1, any1, ov1);
            tests++;
            if (ov1 !== ev) begin fails++; $display("FAIL w1p1_valid[%0d] got %b want %b", i, ov1, ev); end
            tests++;
            if (o1 !== er) begin fails++; $display("FAIL w1p1_out[%0d] got %b want %b", i, o1, er); end
            tests++;
            if (all1 !== er || any1 !== er) begin
                fails++; $display("FAIL w1p1_flags[%0d] got all=%b any=%b want %b", i, all1, any1, er);
            end
            if (i < 4) begin a1 = i[0]; b1 = i[1]; v1 = 1; end
            else begin a1 = 0; b1 = 0; v1 = 0; end
            qa.push_back(a1); qb.push_back(b1); qv.push_back(v1);
        end
    endtask

    task automatic test_w8_p3_stream();
        logic [7:0] sa [3];
        logic [7:0] sb [3];
        logic [7:0] qa[$], qb[$];
        logic qv[$];
        logic [7:0] er;
        logic ev, eall, eany;
        sa = '{8'hF0, 8'hFF, 8'hAA};
        sb = '{8'h3C, 8'hFF, 8'h55};
        for (int k = 0; k < 3; k++) begin qa.push_back(0); qb.push_back(0); qv.push_back(0); end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            er = qa.pop_front() & qb.pop_front(); ev = qv.pop_front();
            eall = (er == 8'hFF); eany = (er != 8'h00);
            $display("[TB] w8p3 cyc%0d out=%h all=%b any=%b v=%b", i, o3, all3, any3, ov3);
            tests++;
            if (ov3 !== ev) begin fails++; $display("FAIL w8p3_valid[%0d] got %b want %b", i, ov3, ev); end
            tests++;
            if (o3 !== er) begin fails++; $display("FAIL w8p3_out[%0d] got %h want %h", i, o3, er); end
            tests++;
            if (all3 !== eall) begin fails++; $display("FAIL w8p3_all[%0d] got %b want %b", i, all3, eall); end
            tests++;
            if (any3 !== eany) begin fails++; $display("FAIL w8p3_any[%0d] got %b want %b", i, any3, eany); end
            if (i < 3) begin a3 = sa[i]; b3 = sb[i]; v3 = 1; end
            else begin a3 = 0; b3 = 0; v3 = 0; end
            qa.push_back(a3); qb.push_back(b3); qv.push_back(v3);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a3 = 8'($urandom) | 8'h01; b3 = 8'hFF; v3 = 1;
        end
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        $display("[TB] midflight reset asserted at %0t out=%h v=%b", $time, o3, ov3);
        tests++;
        if ({ov3, o3, all3, any3} !== 11'b0) begin
            fails++; $display("FAIL midreset_immediate {v,o,all,any} got %h want 000", {ov3, o3, all3, any3});
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({ov3, o3, all3, any3} !== 11'b0) begin
            fails++; $display("FAIL midreset_hold {v,o,all,any} got %h want 000", {ov3, o3, all3, any3});
        end
        a3 = 0; b3 = 0; v3 = 0;
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (ov3 !== 1'b0 || o3 !== 8'h00) begin
                fails++; $display("FAIL midreset_stale[%0d] got v=%b out=%h want v=0 out=00", i, ov3, o3);
            end
        end
    endtask

    task automatic test_valid_toggle();
        logic [7:0] qa[$], qb[$];
        logic qv[$];
        logic [7:0] er;
        logic ev, eall, eany;
        for (int k = 0; k < 2; k++) begin qa.push_back(0); qb.push_back(0); qv.push_back(0); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            er = qa.pop_front() & qb.pop_front(); ev = qv.pop_front();
            eall = (er == 8'hFF); eany = (er != 8'h00);
            $display("[TB] w8p2 cyc%0d out=%h v=%b", i, o2, ov2);
            tests++;
            if (ov2 !== ev) begin fails++; $display("FAIL toggle_valid[%0d] got %b want %b", i, ov2, ev); end
            tests++;
            if (o2 !== er) begin fails++; $display("FAIL toggle_out[%0d] got %h want %h", i, o2, er); end
            tests++;
            if (all2 !== eall || any2 !== eany) begin
                fails++; $display("FAIL toggle_flags[%0d] got all=%b any=%b want all=%b any=%b", i, all2, any2, eall, eany);
            end
            if (i < 3) begin a2 = 8'($urandom); b2 = 8'($urandom); v2 = (i != 1); end
            else begin a2 = 0; b2 = 0; v2 = 0; end
            qa.push_back(a2); qb.push_back(b2); qv.push_back(v2);
        end
    endtask

    task automatic test_random();
        logic [15:0] qa[$], qb[$];
        logic qv[$];
        logic [15:0] er;
        logic ev, eall, eany;
        int sel;
        int nvalid = 0;
        for (int k = 0; k < 4; k++) begin qa.push_back(0); qb.push_back(0); qv.push_back(0); end
        for (int i = 0; i < 1004; i++) begin
            @(negedge clk);
            er = qa.pop_front() & qb.pop_front(); ev = qv.pop_front();
            eall = (er == 16'hFFFF); eany = (er != 16'h0000);
            tests++;
            if (ov4 !== ev) begin fails++; $display("FAIL rand_valid[%0d] got %b want %b", i, ov4, ev); end
            if (ev) begin
                nvalid++;
                tests++;
                if (o4 !== er) begin fails++; $display("FAIL rand_out[%0d] got %h want %h", i, o4, er); end
                tests++;
                if (all4 !== eall) begin fails++; $display("FAIL rand_all[%0d] got %b want %b", i, all4, eall); end
                tests++;
                if (any4 !== eany) begin fails++; $display("FAIL rand_any[%0d] got %b want %b", i, any4, eany); end
            end
            if (i < 1000) begin
                a4 = 16'($urandom); b4 = 16'($urandom); v4 = 1'($urandom);
                sel = int'($urandom_range(7));
                if (sel == 0) begin a4 = 16'hFFFF; b4 = 16'hFFFF; end
                else if (sel == 1) b4 = 16'h0000;
                else if (sel == 2) a4 = 16'hFFFF;
            end else begin
                a4 = 0; b4 = 0; v4 = 0;
            end
            qa.push_back(a4); qb.push_back(b4); qv.push_back(v4);
        end
        $display("[TB] random run checked %0d valid outputs", nvalid);
    endtask

    initial begin
        test_reset();
        test_w1_p0();
        test_w1_p1();
        test_w8_p3_stream();
        test_reset_midflight();
        test_valid_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
